// File: rtl/alu_pkg.sv
// Shared alufn code table and ALU FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  // alufn codes, shared with the ALU control decoder
  localparam logic [3:0] ALUFN_ADD   = 4'b0000;
  localparam logic [3:0] ALUFN_SUB   = 4'b0001;
  localparam logic [3:0] ALUFN_PASSB = 4'b0011;
  localparam logic [3:0] ALUFN_OR    = 4'b0100;
  localparam logic [3:0] ALUFN_AND   = 4'b0101;
  localparam logic [3:0] ALUFN_XOR   = 4'b0111;
  localparam logic [3:0] ALUFN_SLL   = 4'b1000;
  localparam logic [3:0] ALUFN_SRL   = 4'b1001;
  localparam logic [3:0] ALUFN_SRA   = 4'b1010;
  localparam logic [3:0] ALUFN_SLT   = 4'b1101;
  localparam logic [3:0] ALUFN_JALR  = 4'b1110;
  localparam logic [3:0] ALUFN_SLTU  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  function automatic logic is_shift(input logic [3:0] fn);
    return (fn == ALUFN_SLL) || (fn == ALUFN_SRL) || (fn == ALUFN_SRA);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational XLEN adder/subtractor with carry, overflow and set-less-than outputs.
// Latency: 0 cycles (pure combinational).
// Backpressure: none, no state.
module alu_addsub #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_sub,
  output logic [XLEN-1:0] o_sum,
  output logic            o_carry,
  output logic            o_ovf,
  output logic            o_slt,
  output logic            o_sltu
);

  logic [XLEN-1:0] w_b;
  logic [XLEN:0]   w_full;

  // Subtraction is a + ~b + 1, so carry out means a >=u b
  assign w_b     = i_b ^ {XLEN{i_sub}};
  assign w_full  = {1'b0, i_a} + {1'b0, w_b} + {{XLEN{1'b0}}, i_sub};
  assign o_sum   = w_full[XLEN-1:0];
  assign o_carry = w_full[XLEN];
  assign o_ovf   = (i_a[XLEN-1] == w_b[XLEN-1]) && (o_sum[XLEN-1] != i_a[XLEN-1]);
  assign o_slt   = o_sum[XLEN-1] ^ o_ovf;
  assign o_sltu  = ~o_carry;

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle RV32I ALU; shifts iterate 1 bit/cycle unless ALU_FAST_SHIFT_EN selects a barrel shifter.
// Latency: 1 cycle accept->out_valid for non-shifts and shamt=0, shamt cycles for iterative shifts.
// Backpressure: result/flags held in DONE until out_ready; in_ready = IDLE | (DONE & out_ready).
module alu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alufn,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            flag_z,
  output logic            flag_n,
  output logic            flag_c,
  output logic            flag_v
);

  localparam int SW = $clog2(XLEN);

  alu_state_t      r_state, w_state_d;
  logic [XLEN-1:0] r_result, w_res_d;
  logic [SW-1:0]   r_cnt, w_cnt_d;
  logic [3:0]      r_op, w_op_d;
  logic            r_z, r_n, r_c, r_v;
  logic            w_load, w_fin, w_c_d, w_v_d;

  logic [SW-1:0]   w_shamt;
  logic [XLEN-1:0] w_sum, w_alu_res;
  logic            w_sub, w_carry, w_ovf, w_slt, w_sltu, w_alu_c, w_alu_v;

  // One bit of SLL/SRL/SRA; SRA replicates the sign bit
  function automatic logic [XLEN-1:0] f_shift1(input logic [XLEN-1:0] x, input logic [3:0] fn);
    if (fn == ALUFN_SLL)      return {x[XLEN-2:0], 1'b0};
    else if (fn == ALUFN_SRL) return {1'b0, x[XLEN-1:1]};
    else                      return {x[XLEN-1], x[XLEN-1:1]};
  endfunction

  assign w_shamt = op_b[SW-1:0];
  assign w_sub   = (alufn == ALUFN_SUB) || (alufn == ALUFN_SLT) || (alufn == ALUFN_SLTU);

  alu_addsub #(.XLEN(XLEN)) u_addsub (
    .i_a     (op_a),
    .i_b     (op_b),
    .i_sub   (w_sub),
    .o_sum   (w_sum),
    .o_carry (w_carry),
    .o_ovf   (w_ovf),
    .o_slt   (w_slt),
    .o_sltu  (w_sltu)
  );

  // Single-cycle (non-shift) result; carry/overflow only meaningful for ADD/SUB
  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (alufn)
      ALUFN_ADD, ALUFN_SUB: begin
        w_alu_res = w_sum;
        w_alu_c   = w_carry;
        w_alu_v   = w_ovf;
      end
      ALUFN_PASSB: w_alu_res = op_b;
      ALUFN_OR:    w_alu_res = op_a | op_b;
      ALUFN_AND:   w_alu_res = op_a & op_b;
      ALUFN_XOR:   w_alu_res = op_a ^ op_b;
      ALUFN_SLT:   w_alu_res = {{(XLEN-1){1'b0}}, w_slt};
      ALUFN_SLTU:  w_alu_res = {{(XLEN-1){1'b0}}, w_sltu};
      ALUFN_JALR:  w_alu_res = {w_sum[XLEN-1:1], 1'b0};
      default:     w_alu_res = '0;
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN
  logic [XLEN-1:0] w_barrel;

  // Full-width shift in one cycle
  always_comb begin
    case (alufn)
      ALUFN_SLL: w_barrel = op_a << w_shamt;
      ALUFN_SRL: w_barrel = op_a >> w_shamt;
      default:   w_barrel = $signed(op_a) >>> w_shamt;
    endcase
  end
`endif

  // Next state, handshake outputs and datapath load controls
  always_comb begin
    w_state_d = r_state;
    w_res_d   = r_result;
    w_cnt_d   = r_cnt;
    w_op_d    = r_op;
    w_load    = 1'b0;
    w_fin     = 1'b0;
    w_c_d     = 1'b0;
    w_v_d     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_state_d = ST_IDLE;
      end
      ST_BUSY: begin
        w_load  = 1'b1;
        w_res_d = f_shift1(r_result, r_op);
        w_cnt_d = r_cnt - 1'b1;
        if (r_cnt == SW'(1)) begin
          w_state_d = ST_DONE;
          w_fin     = 1'b1;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
    if (in_valid && in_ready) begin
      w_op_d = alufn;
      w_load = 1'b1;
      if (is_shift(alufn)) begin
`ifdef ALU_FAST_SHIFT_EN
        w_res_d   = w_barrel;
        w_fin     = 1'b1;
        w_state_d = ST_DONE;
`else
        // First bit is shifted on the accept edge; counter holds the bits still to go
        if (w_shamt == '0) begin
          w_res_d   = op_a;
          w_fin     = 1'b1;
          w_state_d = ST_DONE;
        end else begin
          w_res_d = f_shift1(op_a, alufn);
          w_cnt_d = w_shamt - 1'b1;
          if (w_shamt == SW'(1)) begin
            w_fin     = 1'b1;
            w_state_d = ST_DONE;
          end else begin
            w_state_d = ST_BUSY;
          end
        end
`endif
      end else begin
        w_res_d   = w_alu_res;
        w_c_d     = w_alu_c;
        w_v_d     = w_alu_v;
        w_fin     = 1'b1;
        w_state_d = ST_DONE;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_d;
  end

  // Result/counter registers; flags latched from the final result on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
    end else begin
      if (w_load) begin
        r_result <= w_res_d;
        r_cnt    <= w_cnt_d;
        r_op     <= w_op_d;
      end
      if (w_fin) begin
        r_z <= (w_res_d == '0);
        r_n <= w_res_d[XLEN-1];
        r_c <= w_c_d;
        r_v <= w_v_d;
      end
    end
  end

  assign result = r_result;
  assign flag_z = r_z;
  assign flag_n = r_n;
  assign flag_c = r_c;
  assign flag_v = r_v;

endmodule
